// File: rtl/led_pattern_monitor.sv
// Watches a bound-flasher LED bus, decodes the lit-LED count and tracks sweep
// direction, reversals, completed sweeps and coding/step errors.
module led_pattern_monitor (
  input  logic        div_clk,
  input  logic        rst,
  input  logic [15:0] led,
  output logic [4:0]  count,
  output logic [1:0]  dir,
  output logic        kick,
  output logic        done,
  output logic [4:0]  peak,
  output logic [7:0]  sweeps,
  output logic        err_pat,
  output logic        err_step,
  output logic        err_any
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] prev_q, prev_d;
  logic [4:0] count_q, count_d;
  logic [4:0] peak_q, peak_d;
  logic [4:0] run_max_q, run_max_d;
  logic [7:0] sweeps_q, sweeps_d;
  logic       kick_q, kick_d;
  logic       done_q, done_d;
  logic       err_pat_q, err_pat_d;
  logic       err_step_q, err_step_d;
  logic       err_any_q, err_any_d;

  // A lit LED above an unlit one breaks the thermometer code.
  logic [14:0] hole;
  logic        legal;
  logic [4:0]  ones;
  logic        step_big;

  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_hole
      assign hole[gi] = led[gi+1] & ~led[gi];
    end
  endgenerate

  assign legal = ~|hole;

  always_comb begin
    ones = 5'd0;
    for (int i = 0; i < 16; i++) begin
      ones = ones + 5'(led[i]);
    end
  end

  assign step_big = (ones > prev_q) ? ((ones - prev_q) > 5'd1)
                                    : ((prev_q - ones) > 5'd1);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    count_d    = count_q;
    peak_d     = peak_q;
    run_max_d  = run_max_q;
    sweeps_d   = sweeps_q;
    kick_d     = 1'b0;
    done_d     = 1'b0;
    err_pat_d  = 1'b0;
    err_step_d = 1'b0;
    err_any_d  = err_any_q;

    if (!legal) begin
      // Illegal samples freeze all tracking state; only the error flags move.
      err_pat_d = 1'b1;
      err_any_d = 1'b1;
    end else begin
      err_step_d = step_big;
      if (step_big) begin
        err_any_d = 1'b1;
      end
      prev_d  = ones;
      count_d = ones;
      if (ones > run_max_q) begin
        run_max_d = ones;
      end

      case (state_q)
        ST_IDLE: begin
          if (ones > prev_q) begin
            state_d = ST_UP;
          end else begin
            run_max_d = 5'd0;
          end
        end
        ST_UP: begin
          if (ones < prev_q) begin
            state_d = ST_DOWN;
            kick_d  = 1'b1;
          end
        end
        ST_DOWN: begin
          if (ones == 5'd0) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            peak_d    = run_max_q;
            run_max_d = 5'd0;
            if (sweeps_q != 8'hFF) begin
              sweeps_d = sweeps_q + 8'd1;
            end
          end else if (ones > prev_q) begin
            state_d = ST_UP;
            kick_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge div_clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      prev_q     <= 5'd0;
      count_q    <= 5'd0;
      peak_q     <= 5'd0;
      run_max_q  <= 5'd0;
      sweeps_q   <= 8'd0;
      kick_q     <= 1'b0;
      done_q     <= 1'b0;
      err_pat_q  <= 1'b0;
      err_step_q <= 1'b0;
      err_any_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      count_q    <= count_d;
      peak_q     <= peak_d;
      run_max_q  <= run_max_d;
      sweeps_q   <= sweeps_d;
      kick_q     <= kick_d;
      done_q     <= done_d;
      err_pat_q  <= err_pat_d;
      err_step_q <= err_step_d;
      err_any_q  <= err_any_d;
    end
  end

  assign count    = count_q;
  assign dir      = state_q;
  assign kick     = kick_q;
  assign done     = done_q;
  assign peak     = peak_q;
  assign sweeps   = sweeps_q;
  assign err_pat  = err_pat_q;
  assign err_step = err_step_q;
  assign err_any  = err_any_q;

endmodule
